display_scan_controller: RTL and testbench

//  Sequencer for the 2-digit 7-segment status display of the level-sensor board. Debounces BUTTON,

---
 rtl/display_pkg.sv | 40 ++++
 rtl/button_debounce.sv | 48 ++++
 rtl/display_scan_controller.sv | 116 +++++++++++
 tb/tb_display_scan_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types, glyph constants and helpers for the 2-digit status display.
// Pure declarations: no latency, no flow control.
package display_pkg;

  typedef enum logic {IDLE, SHOW} state_t;

  typedef enum logic [1:0] {AC, CO, RE, ERR} code_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_C     = 7'b0111001;
  localparam logic [6:0] GLYPH_O     = 7'b0111111;
  localparam logic [6:0] GLYPH_R     = 7'b1010000;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic code_t decode_code(input logic [2:0] sens);
    case (sens)
      3'b100:  return AC;
      3'b010:  return CO;
      3'b001:  return RE;
      default: return ERR;
    endcase
  endfunction

  // Returns {left_glyph, right_glyph}.
  function automatic logic [13:0] code_glyphs(input code_t c);
    case (c)
      AC:      return {GLYPH_A, GLYPH_C};
      CO:      return {GLYPH_C, GLYPH_O};
      RE:      return {GLYPH_R, GLYPH_E};
      default: return {GLYPH_E, GLYPH_R};
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button synchronizer + debouncer: press pulse 2 + DEB_CYCLES cycles after a clean rise.
// No backpressure; o_press is a single-cycle pulse per accepted 0->1 level change.
module button_debounce
  import display_pkg::*;
#(
  parameter int DEB_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = cnt_w(DEB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        // Pulse is registered together with the level flip, so it fires once per rise.
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/display_scan_controller.sv
// Latches sensor code on each debounced press and scans it onto two 7-seg digits for HOLD_CYCLES.
// First segment lit 2 + DEB_CYCLES + 2 cycles after BUTTON rise; no backpressure on the pins.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int DEB_CYCLES  = 250000,
  parameter int SCAN_CYCLES = 50000,
  parameter int HOLD_CYCLES = 150000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_button,
  input  logic       i_entrada_ac,
  input  logic       i_entrada_co,
  input  logic       i_entrada_re,
  output logic [6:0] o_seg,
  output logic [1:0] o_dig,
  output logic       o_erro
);

  localparam int SW = cnt_w(SCAN_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);

  logic          w_press;
  logic [2:0]    r_sens_s1;
  logic [2:0]    r_sens_s2;
  state_t        r_state;
  state_t        w_state_nxt;
  code_t         r_code;
  logic [HW-1:0] r_hold;
  logic [SW-1:0] r_scan;
  logic          r_sel_right;
  logic          w_hold_done;
  logic [13:0]   w_pair;
  logic [6:0]    w_seg_nxt;
  logic [1:0]    w_dig_nxt;
  logic [6:0]    r_seg;
  logic [1:0]    r_dig;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_button),
    .o_press (w_press)
  );

  assign w_hold_done = (r_hold == HW'(HOLD_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_press) w_state_nxt = SHOW;
      SHOW:    if (!w_press && w_hold_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sens_s1   <= 3'b000;
      r_sens_s2   <= 3'b000;
      r_code      <= AC;
      r_hold      <= '0;
      r_scan      <= '0;
      r_sel_right <= 1'b0;
    end else begin
      r_sens_s1 <= {i_entrada_ac, i_entrada_co, i_entrada_re};
      r_sens_s2 <= r_sens_s1;
      if (w_press) r_code <= decode_code(r_sens_s2);

      if (w_press || r_state != SHOW || w_hold_done) r_hold <= '0;
      else                                           r_hold <= r_hold + HW'(1);

      // A press while already showing keeps the scan phase running.
      if (r_state == IDLE) begin
        r_scan      <= '0;
        r_sel_right <= 1'b0;
      end else if (r_scan == SW'(SCAN_CYCLES - 1)) begin
        r_scan      <= '0;
        r_sel_right <= ~r_sel_right;
      end else begin
        r_scan <= r_scan + SW'(1);
      end
    end
  end

  always_comb begin
    w_pair    = code_glyphs(r_code);
    w_seg_nxt = GLYPH_BLANK;
    w_dig_nxt = 2'b00;
    if (r_state == SHOW) begin
      w_dig_nxt = r_sel_right ? 2'b01 : 2'b10;
      w_seg_nxt = r_sel_right ? w_pair[6:0] : w_pair[13:7];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg <= GLYPH_BLANK;
      r_dig <= 2'b00;
    end else begin
      r_seg <= w_seg_nxt;
      r_dig <= w_dig_nxt;
    end
  end

  assign o_seg  = r_seg;
  assign o_dig  = r_dig;
  assign o_erro = (r_code == ERR);

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench: expected lit frames are queued by the stimulus, a monitor pops them per lit cycle.
module tb_display_scan_controller;

  localparam int DEB  = 4;
  localparam int SCAN = 3;
  localparam int HOLD = 20;

  localparam logic [6:0] G_A = 7'b1110111;
  localparam logic [6:0] G_C = 7'b0111001;
  localparam logic [6:0] G_O = 7'b0111111;
  localparam logic [6:0] G_R = 7'b1010000;
  localparam logic [6:0] G_E = 7'b1111001;

  typedef struct packed {
    logic [1:0] dig;
    logic [6:0] seg;
    logic       erro;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       button = 1'b0;
  logic       ac = 1'b0;
  logic       co = 1'b0;
  logic       re = 1'b0;
  logic [6:0] o_seg;
  logic [1:0] o_dig;
  logic       o_erro;

  int     n_tests = 0;
  int     n_fail  = 0;
  frame_t exp_q[$];
  frame_t mon_exp;
  int     lat;

  display_scan_controller #(
    .DEB_CYCLES  (DEB),
    .SCAN_CYCLES (SCAN),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_button     (button),
    .i_entrada_ac (ac),
    .i_entrada_co (co),
    .i_entrada_re (re),
    .o_seg        (o_seg),
    .o_dig        (o_dig),
    .o_erro       (o_erro)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Queue `count` lit frames starting at frame index `first` of a SHOW run.
  task automatic push_show(input logic [6:0] gl, input logic [6:0] gr, input logic erro,
                           input int first, input int count);
    frame_t f;
    for (int i = first; i < first + count; i++) begin
      if (((i / SCAN) % 2) == 0) f = '{dig: 2'b10, seg: gl, erro: erro};
      else                       f = '{dig: 2'b01, seg: gr, erro: erro};
      exp_q.push_back(f);
    end
  endtask

  // Clean press: rise now (at a negedge), hold for 6 cycles, release.
  task automatic press();
    button = 1'b1;
    tick(6);
    button = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rst_n && o_dig != 2'b00) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_lit: dig=%b seg=%b erro=%b, required blank", o_dig, o_seg, o_erro);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({o_dig, o_seg, o_erro} !== mon_exp) begin
          n_fail++;
          $display("FAIL frame: got dig=%b seg=%b erro=%b, required dig=%b seg=%b erro=%b",
                   o_dig, o_seg, o_erro, mon_exp.dig, mon_exp.seg, mon_exp.erro);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset and idle
    #1 rst_n = 1'b0;
    tick(3);
    check("reset_seg", 32'(o_seg), 32'h0);
    check("reset_dig", 32'(o_dig), 32'h0);
    check("reset_erro", 32'(o_erro), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_outputs", 32'({o_seg, o_dig, o_erro}), 32'h0);
    end

    // 2: AC press, latency and full scan/hold sequence
    ac = 1'b1;
    tick(3);
    push_show(G_A, G_C, 1'b0, 0, 20);
    lat = 0;
    fork
      press();
      begin
        while (lat < 20 && o_dig == 2'b00) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    check("press_latency", 32'(lat), 32'd8);
    tick(30);
    check("ac_drain", 32'(exp_q.size()), 32'd0);

    // 3: bounce shorter than the debounce window
    for (int i = 0; i < 5; i++) begin
      button = 1'b1;
      tick(2);
      button = 1'b0;
      tick(2);
    end
    tick(20);
    check("bounce_blank", 32'({o_seg, o_dig}), 32'h0);

    // 4: CO, then relatch to RE ten cycles into SHOW
    ac = 1'b0;
    co = 1'b1;
    tick(3);
    push_show(G_C, G_O, 1'b0, 0, 16);
    push_show(G_R, G_E, 1'b0, 16, 20);
    press();
    tick(10);
    co = 1'b0;
    re = 1'b1;
    press();
    tick(40);
    check("relatch_drain", 32'(exp_q.size()), 32'd0);

    // 5: invalid sensor combination, then valid again
    ac = 1'b1;
    co = 1'b1;
    re = 1'b0;
    tick(3);
    push_show(G_E, G_R, 1'b1, 0, 20);
    press();
    tick(30);
    check("err_drain", 32'(exp_q.size()), 32'd0);
    check("erro_held_idle", 32'(o_erro), 32'd1);
    check("err_blank", 32'(o_dig), 32'd0);
    ac = 1'b0;
    co = 1'b0;
    re = 1'b1;
    tick(3);
    push_show(G_R, G_E, 1'b0, 0, 20);
    press();
    tick(30);
    check("valid_drain", 32'(exp_q.size()), 32'd0);
    check("erro_cleared", 32'(o_erro), 32'd0);

    // 6: reset in the middle of SHOW
    ac = 1'b1;
    re = 1'b0;
    tick(3);
    push_show(G_A, G_C, 1'b0, 0, 5);
    press();
    tick(6);
    rst_n = 1'b0;
    #1;
    check("midreset_seg", 32'(o_seg), 32'h0);
    check("midreset_dig", 32'(o_dig), 32'h0);
    check("midreset_erro", 32'(o_erro), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(30);
    check("midreset_drain", 32'(exp_q.size()), 32'd0);
    check("after_reset_blank", 32'({o_seg, o_dig}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
